// File: rtl/tmds_encoder_multi.sv
// Multi-lane pipelined TMDS encoder: video (8b/10b with running disparity), control,
// TERC4 data island and guard-band symbols. Two enabled clock cycles from input to tmds.
module tmds_encoder_multi #(
    parameter int NUM_CH = 3,
    parameter int CNT_W  = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ce,
    input  logic [2:0]            mode,
    input  logic [8*NUM_CH-1:0]   vd,
    input  logic [2*NUM_CH-1:0]   cd,
    input  logic [4*NUM_CH-1:0]   aux,
    output logic [10*NUM_CH-1:0]  tmds
);

    typedef enum logic [2:0] {
        MODE_CTRL  = 3'd0,
        MODE_VIDEO = 3'd1,
        MODE_TERC4 = 3'd2,
        MODE_VGB   = 3'd3,
        MODE_DGB   = 3'd4
    } mode_e;

    localparam logic [9:0] SYM_CTRL00 = 10'b1101010100;
    localparam logic [9:0] SYM_GB_A   = 10'b1011001100;
    localparam logic [9:0] SYM_GB_B   = 10'b0100110011;

    function automatic logic [9:0] ctrl_sym(input logic [1:0] c);
        case (c)
            2'b00:   return 10'b1101010100;
            2'b01:   return 10'b0010101011;
            2'b10:   return 10'b0101010100;
            default: return 10'b1010101011;
        endcase
    endfunction

    function automatic logic [9:0] terc4_sym(input logic [3:0] a);
        case (a)
            4'h0: return 10'b1010011100;
            4'h1: return 10'b1001100011;
            4'h2: return 10'b1011100100;
            4'h3: return 10'b1011100010;
            4'h4: return 10'b0101110001;
            4'h5: return 10'b0100011110;
            4'h6: return 10'b0110001110;
            4'h7: return 10'b0100111100;
            4'h8: return 10'b1011001100;
            4'h9: return 10'b0100111001;
            4'hA: return 10'b0110011100;
            4'hB: return 10'b1011000110;
            4'hC: return 10'b1010001110;
            4'hD: return 10'b1001110001;
            4'hE: return 10'b0101100011;
            default: return 10'b1011000011;
        endcase
    endfunction

    for (genvar g = 0; g < NUM_CH; g++) begin : g_lane
        localparam int ROLE = g % 3;

        logic [7:0]              d;
        logic [3:0]              d_ones;
        logic                    use_xnor;
        logic [8:0]              qm_d, qm_q;
        mode_e                   mode_q;
        logic [1:0]              cd_q;
        logic [3:0]              aux_q;
        logic [3:0]              n1;
        logic signed [CNT_W-1:0] n1_s, n0_s, two_q8, two_nq8;
        logic signed [CNT_W-1:0] cnt_d, cnt_q;
        logic [9:0]              sym_d, sym_q;

        assign d = vd[8*g +: 8];

        // Stage 1: transition-minimising chain.
        always_comb begin
            d_ones = '0;
            for (int k = 0; k < 8; k++) d_ones = d_ones + 4'(d[k]);
            use_xnor = (d_ones > 4'd4) || (d_ones == 4'd4 && !d[0]);
            qm_d    = '0;
            qm_d[0] = d[0];
            for (int k = 1; k < 8; k++)
                qm_d[k] = use_xnor ? ~(qm_d[k-1] ^ d[k]) : (qm_d[k-1] ^ d[k]);
            qm_d[8] = ~use_xnor;
        end

        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        always_ff @(posedge clk) begin
            if (rst) begin
                qm_q   <= '0;
                mode_q <= MODE_CTRL;
                cd_q   <= 2'b00;
                aux_q  <= '0;
            end else if (ce) begin
                qm_q   <= qm_d;
                mode_q <= mode_e'(mode);
                cd_q   <= cd[2*g +: 2];
                aux_q  <= aux[4*g +: 4];
            end
        end

        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        always_comb begin
            n1 = '0;
            for (int k = 0; k < 8; k++) n1 = n1 + 4'(qm_q[k]);
            n1_s    = CNT_W'(n1);
            n0_s    = CNT_W'(4'd8 - n1);
            two_q8  = qm_q[8] ? CNT_W'(2) : CNT_W'(0);
            two_nq8 = qm_q[8] ? CNT_W'(0) : CNT_W'(2);
            sym_d   = ctrl_sym(cd_q);
            cnt_d   = '0;
            case (mode_q)
                MODE_VIDEO: begin
                    if (cnt_q == '0 || n1 == 4'd4) begin
                        sym_d = {~qm_q[8], qm_q[8], qm_q[8] ? qm_q[7:0] : ~qm_q[7:0]};
                        cnt_d = qm_q[8] ? cnt_q + n1_s - n0_s : cnt_q + n0_s - n1_s;
                    // cnt is known non-zero here, so the sign bit alone decides its polarity.
                    end else if ((!cnt_q[CNT_W-1] && n1 > 4'd4) || (cnt_q[CNT_W-1] && n1 < 4'd4)) begin
                        sym_d = {1'b1, qm_q[8], ~qm_q[7:0]};
                        cnt_d = cnt_q + two_q8 + n0_s - n1_s;
                    end else begin
                        sym_d = {1'b0, qm_q[8], qm_q[7:0]};
                        cnt_d = cnt_q + n1_s - n0_s - two_nq8;
                    end
                end
                MODE_TERC4: sym_d = terc4_sym(aux_q);
                MODE_VGB:   sym_d = (ROLE == 1) ? SYM_GB_B : SYM_GB_A;
                MODE_DGB:   sym_d = (ROLE == 0) ? terc4_sym(aux_q) : SYM_GB_B;
                default:    ;
            endcase
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                sym_q <= SYM_CTRL00;
                cnt_q <= '0;
            end else if (ce) begin
                sym_q <= sym_d;
                cnt_q <= cnt_d;
            end
        end

        assign tmds[10*g +: 10] = sym_q;
    end

endmodule

// File: tb/tb_tmds_encoder_multi.sv
// Bench for tmds_encoder_multi: a 3-lane and a 6-lane instance share stimulus and are
// checked against a cycle-level reference model plus table-driven and hand-written sequences.
module tb_tmds_encoder_multi;

    localparam logic [9:0] C00  = 10'b1101010100;
    localparam logic [9:0] C01  = 10'b0010101011;
    localparam logic [9:0] C10  = 10'b0101010100;
    localparam logic [9:0] C11  = 10'b1010101011;
    localparam logic [9:0] GB_A = 10'b1011001100;
    localparam logic [9:0] GB_B = 10'b0100110011;

    logic [9:0] terc4_tab [16] = '{
        10'b1010011100, 10'b1001100011, 10'b1011100100, 10'b1011100010,
        10'b0101110001, 10'b0100011110, 10'b0110001110, 10'b0100111100,
        10'b1011001100, 10'b0100111001, 10'b0110011100, 10'b1011000110,
        10'b1010001110, 10'b1001110001, 10'b0101100011, 10'b1011000011
    };

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ce  = 1'b1;
    logic [2:0]  mode = 3'd0;
    logic [47:0] vd  = '0;
    logic [11:0] cd  = '0;
    logic [23:0] aux = '0;
    logic [59:0] tmds6;
    logic [29:0] tmds3;

    int total = 0;
    int bad   = 0;

    tmds_encoder_multi dut3 (
        .clk(clk), .rst(rst), .ce(ce), .mode(mode),
        .vd(vd[23:0]), .cd(cd[5:0]), .aux(aux[11:0]), .tmds(tmds3)
    );

    tmds_encoder_multi #(.NUM_CH(6), .CNT_W(5)) dut6 (
        .clk(clk), .rst(rst), .ce(ce), .mode(mode),
        .vd(vd), .cd(cd), .aux(aux), .tmds(tmds6)
    );

    always #5 clk = ~clk;

    // Reference model state: symbol waiting in the pipe and symbol on the output.
    logic [9:0] stage_m [6];
    logic [9:0] out_m   [6];
    int         cnt_m   [6];
    int         disp    [6];
    bit         stage_vid, out_vid, model_valid;
    int         max_disp;

    task automatic check(input string name, input logic [59:0] got, input logic [59:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    function automatic logic [9:0] ctrl_code(input logic [1:0] c);
        case (c)
            2'b00:   return C00;
            2'b01:   return C01;
            2'b10:   return C10;
            default: return C11;
        endcase
    endfunction

    // q_m bit k is the parity of d[0..k], inverted on odd k when the XNOR chain is chosen.
    function automatic logic [9:0] video_model(input int lane, input logic [7:0] d);
        int         ones, n1, bal, q8;
        bit         inv;
        logic [8:0] q;
        logic [9:0] sym;
        logic [7:0] mask;
        ones = $countones(d);
        inv  = (ones > 4) || (ones == 4 && d[0] == 1'b0);
        for (int k = 0; k < 8; k++) begin
            mask = 8'((1 << (k + 1)) - 1);
            q[k] = (^(d & mask)) ^ (inv & (k % 2 == 1));
        end
        q[8] = !inv;
        q8   = int'(q[8]);
        n1   = $countones(q[7:0]);
        bal  = n1 - (8 - n1);
        if (cnt_m[lane] == 0 || bal == 0) begin
            sym = {~q[8], q[8], q[8] ? q[7:0] : ~q[7:0]};
            cnt_m[lane] += (q8 == 1) ? bal : -bal;
        end else if ((cnt_m[lane] > 0 && bal > 0) || (cnt_m[lane] < 0 && bal < 0)) begin
            sym = {1'b1, q[8], ~q[7:0]};
            cnt_m[lane] += 2 * q8 - bal;
        end else begin
            sym = {1'b0, q[8], q[7:0]};
            cnt_m[lane] += bal - 2 * (1 - q8);
        end
        return sym;
    endfunction

    function automatic logic [9:0] lane_model(input int lane);
        logic [3:0] a;
        a = aux[4*lane +: 4];
        if (mode == 3'd1) return video_model(lane, vd[8*lane +: 8]);
        cnt_m[lane] = 0;
        case (mode)
            3'd2:    return terc4_tab[a];
            3'd3:    return (lane % 3 == 1) ? GB_B : GB_A;
            3'd4:    return (lane % 3 == 0) ? terc4_tab[a] : GB_B;
            default: return ctrl_code(cd[2*lane +: 2]);
        endcase
    endfunction

    function automatic logic [59:0] model_bus();
        logic [59:0] b;
        for (int i = 0; i < 6; i++) b[10*i +: 10] = out_m[i];
        return b;
    endfunction

    // One clock: model advances on the edge, DUT outputs are sampled 1 time unit later.
    task automatic step();
        bit          r, en;
        logic [59:0] e;
        int          s;
        r  = rst;
        en = ce;
        @(posedge clk);
        if (r) begin
            for (int i = 0; i < 6; i++) begin
                out_m[i] = C00; stage_m[i] = C00; cnt_m[i] = 0;
            end
            out_vid = 1'b0; stage_vid = 1'b0; model_valid = 1'b1;
        end else if (en) begin
            for (int i = 0; i < 6; i++) out_m[i] = stage_m[i];
            out_vid = stage_vid;
            for (int i = 0; i < 6; i++) stage_m[i] = lane_model(i);
            stage_vid = (mode == 3'd1);
        end
        #1;
        if (model_valid) begin
            e = model_bus();
            check("model_6lane", tmds6, e);
            check("model_3lane", {30'b0, tmds3}, {30'b0, e[29:0]});
            for (int i = 0; i < 6; i++) begin
                if (r || (en && !out_vid)) disp[i] = 0;
                else if (en) begin
                    s = $countones(tmds6[10*i +: 10]);
                    disp[i] += 2 * s - 10;
                    if (disp[i] > max_disp)  max_disp = disp[i];
                    if (-disp[i] > max_disp) max_disp = -disp[i];
                end
            end
        end
    endtask

    task automatic check_all(input string name, input logic [9:0] e0, input logic [9:0] e1, input logic [9:0] e2);
        check({name, "_6"}, tmds6, {e2, e1, e0, e2, e1, e0});
        check({name, "_3"}, {30'b0, tmds3}, {30'b0, e2, e1, e0});
    endtask

    task automatic rand_inputs();
        vd  = 48'({$urandom(), $urandom()});
        cd  = 12'($urandom());
        aux = 24'($urandom());
    endtask

    typedef struct {
        logic [2:0] mode;
        logic [1:0] cd;
        logic [3:0] aux;
        logic [9:0] e0, e1, e2;
    } vec_t;

    initial begin
        vec_t vecs[$];
        vec_t v;

        for (int i = 0; i < 6; i++) disp[i] = 0;
        max_disp = 0; model_valid = 1'b0;

        for (int a = 0; a < 16; a++) begin
            v.mode = 3'd2; v.cd = 2'b00; v.aux = 4'(a);
            v.e0 = terc4_tab[a]; v.e1 = terc4_tab[a]; v.e2 = terc4_tab[a];
            vecs.push_back(v);
        end
        vecs.push_back('{3'd0, 2'b00, 4'h0, C00, C00, C00});
        vecs.push_back('{3'd0, 2'b01, 4'h0, C01, C01, C01});
        vecs.push_back('{3'd0, 2'b10, 4'h0, C10, C10, C10});
        vecs.push_back('{3'd0, 2'b11, 4'h0, C11, C11, C11});
        vecs.push_back('{3'd5, 2'b01, 4'h3, C01, C01, C01});
        vecs.push_back('{3'd6, 2'b10, 4'h7, C10, C10, C10});
        vecs.push_back('{3'd7, 2'b11, 4'hF, C11, C11, C11});
        vecs.push_back('{3'd3, 2'b00, 4'h0, GB_A, GB_B, GB_A});
        vecs.push_back('{3'd4, 2'b00, 4'hC, 10'b1010001110, GB_B, GB_B});
        vecs.push_back('{3'd4, 2'b11, 4'h0, 10'b1010011100, GB_B, GB_B});

        // Reset with arbitrary inputs, then release into control cd=11.
        rst = 1'b1; mode = 3'd1; rand_inputs();
        step(); rand_inputs(); step();
        check_all("reset_state", C00, C00, C00);
        rst = 1'b0; mode = 3'd0; cd = '1;
        step();
        check_all("release_1", C00, C00, C00);
        step();
        check_all("release_2", C11, C11, C11);

        // Table-driven control / TERC4 / guard-band symbols.
        foreach (vecs[k]) begin
            mode = vecs[k].mode;
            cd   = {6{vecs[k].cd}};
            aux  = {6{vecs[k].aux}};
            vd   = 48'({$urandom(), $urandom()});
            step(); step();
            check_all($sformatf("vec%0d_m%0d", k, vecs[k].mode), vecs[k].e0, vecs[k].e1, vecs[k].e2);
        end

        // Video zeros from cnt=0, then video->control->video restarts disparity.
        mode = 3'd0; cd = '0; step(); step();
        mode = 3'd1; vd = '0;
        step();
        step(); check_all("zeros_1", 10'b0100000000, 10'b0100000000, 10'b0100000000);
        step(); check_all("zeros_2", 10'b1111111111, 10'b1111111111, 10'b1111111111);
        mode = 3'd0; cd = '0;
        step(); check_all("zeros_3", 10'b0100000000, 10'b0100000000, 10'b0100000000);
        mode = 3'd1; vd = '0;
        step(); check_all("zeros_ctrl", C00, C00, C00);
        mode = 3'd0;
        step(); check_all("zeros_restart", 10'b0100000000, 10'b0100000000, 10'b0100000000);

        // Mid-frame reset with ce low: rst wins, next two enabled outputs are control 00.
        mode = 3'd1;
        for (int i = 0; i < 5; i++) begin rand_inputs(); step(); end
        rst = 1'b1; ce = 1'b0; rand_inputs();
        step(); check_all("midreset_0", C00, C00, C00);
        rst = 1'b0; ce = 1'b1; rand_inputs();
        step(); check_all("midreset_1", C00, C00, C00);
        rand_inputs(); step();

        // Random video, independent lanes, pseudo-random ce and occasional mode changes.
        for (int n = 0; n < 10000; n++) begin
            rand_inputs();
            ce   = ($urandom_range(0, 3) != 0);
            mode = ($urandom_range(0, 31) == 0) ? 3'($urandom_range(0, 7)) : 3'd1;
            step();
        end
        ce = 1'b1;

        total++;
        if (max_disp > 10) begin
            bad++;
            $display("FAIL disparity_bound got=%0d limit=10", max_disp);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
